// File: rtl/axil_regbus_bridge.sv
// axil_regbus_bridge: AXI4-lite slave to single-outstanding req/ack register bus.
// One transaction in flight; B/R responses carry SLVERR when the peripheral flags reg_err.
// Optional feature macro: AXIL_BRIDGE_TIMEOUT_EN -- abort a request that waits
// TIMEOUT_CYCLES without reg_ack, answering SLVERR (reads return 32'hDEAD_BEEF).
module axil_regbus_bridge #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [31:0]           s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic                  reg_ack,
  input  logic [31:0]           reg_rdata,
  input  logic                  reg_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    WR_REQ,
    RD_REQ,
    B_RESP,
    R_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:2] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            resp_q;
  logic [31:0]           rdata_q;

  logic aw_hs, w_hs, ar_hs;
  logic req_active;
  logic ack_hit;
  logic tmo_hit;

  assign req_active = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign ack_hit    = req_active && reg_ack;

`ifdef AXIL_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Expiry is judged on the count including the current ack-less cycle,
  // so reg_req stays high for exactly TIMEOUT_CYCLES cycles; an ack wins.
  assign tmo_hit = req_active && !reg_ack &&
                   ((tmo_cnt_q + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Wait counter: held at zero outside the request states, counts ack-less request cycles.
  always_ff @(posedge clk) begin
    if (reset || !req_active) begin
      tmo_cnt_q <= '0;
    end else if (!reg_ack) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and AXI ready generation; readies are forced low while in reset.
  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        s_axi_arready = !s_axi_awvalid && !s_axi_wvalid;
        if (s_axi_awvalid && s_axi_wvalid) state_d = WR_REQ;
        else if (s_axi_awvalid)            state_d = WAIT_W;
        else if (s_axi_wvalid)             state_d = WAIT_AW;
        else if (s_axi_arvalid)            state_d = RD_REQ;
      end
      WAIT_W: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) state_d = WR_REQ;
      end
      WAIT_AW: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) state_d = WR_REQ;
      end
      WR_REQ: if (reg_ack || tmo_hit) state_d = B_RESP;
      RD_REQ: if (reg_ack || tmo_hit) state_d = R_RESP;
      B_RESP: if (s_axi_bready) state_d = IDLE;
      R_RESP: if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_arready = 1'b0;
    end
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs  = s_axi_wvalid  && s_axi_wready;
    ar_hs = s_axi_arvalid && s_axi_arready;
  end

  // State register plus capture of address/data on handshake and response on ack/expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs)      addr_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
      else if (ar_hs) addr_q <= s_axi_araddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (ack_hit) begin
        resp_q <= reg_err ? 2'b10 : 2'b00;
        if (state_q == RD_REQ) rdata_q <= reg_rdata;
      end else if (tmo_hit) begin
        resp_q <= 2'b10;
        if (state_q == RD_REQ) rdata_q <= 32'hDEAD_BEEF;
      end
    end
  end

  assign s_axi_bvalid = (state_q == B_RESP);
  assign s_axi_bresp  = resp_q;
  assign s_axi_rvalid = (state_q == R_RESP);
  assign s_axi_rresp  = resp_q;
  assign s_axi_rdata  = rdata_q;

  assign reg_req   = req_active;
  assign reg_we    = (state_q == WR_REQ);
  assign reg_addr  = {addr_q, 2'b00};
  assign reg_wdata = wdata_q;
  assign reg_wstrb = reg_we ? wstrb_q : 4'b0000;

  // Protection bits, address bits outside the register window and the
  // timeout length (in the default build) have no function here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr,
                           s_axi_araddr, 32'(TIMEOUT_CYCLES)};

endmodule
